load_store_unit: RTL

Memory-stage load/store unit between the core's execute/ALU result and a word-addressed data memory with a req/gnt/rvalid handshake.
- Generates byte enables and lane-replicated store data for SB/SH/SW.
- Extracts and sign/zero-extends load data for LB/LH/LW/LBU/LHU.
- Stalls the pipeline until each access completes.
- Detects misaligned or illegal accesses without touching memory.

---
 rtl/lsu_pkg.sv | 7 +
 rtl/lsu_load_align.sv | 21 ++
 rtl/load_store_unit.sv | 97 +++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, byte-enable constants and FSM state type for the load/store unit
package lsu_pkg;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;
  localparam logic [3:0] BE_WORD = 4'b1111, BE_HALF_LO = 4'b0011, BE_HALF_HI = 4'b1100;
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE, ST_ERR} lsu_state_t;
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half lane of a read word and sign/zero-extends it
//   rdata  : raw memory word
//   addr   : byte offset within the word
//   funct3 : load size/sign code
//   result : aligned, extended load value
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);
  logic [7:0] b;
  logic [15:0] h;
  assign b = rdata[{addr, 3'b000} +: 8];
  assign h = addr[1] ? rdata[31:16] : rdata[15:0];
  always_comb
    result = (funct3 == LB || funct3 == LBU) ? {{24{b[7] & ~funct3[2]}}, b} :
             (funct3 == LH || funct3 == LHU) ? {{16{h[15] & ~funct3[2]}}, h} : rdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage LSU with req/gnt/rvalid data-memory handshake and pipeline stall
//   ex_*    : access request from execute (valid, rd/wr enables, funct3, byte address, store data)
//   stall   : hold upstream stage while an access is in flight
//   ld_*    : one-cycle load-result pulse and aligned/extended data
//   err     : one-cycle pulse for misaligned or illegal accesses (memory untouched)
//   mem_*   : word-addressed memory request port
//   Optional LSU_TIMEOUT_EN: abort to err after TIMEOUT_CYCLES cycles in REQ+WAIT.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_rd_en,
  input  logic        ex_wr_en,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        stall,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  lsu_state_t state, nxt;
  logic [2:0] ld_f3;
  logic [1:0] ld_lo;
  logic [31:0] ld_res, st_wdata;
  logic [3:0] st_be;
  logic new_acc, f3_ok, mis, bad, tmo;
  assign new_acc = ex_valid && (ex_rd_en || ex_wr_en);
  assign f3_ok = ex_wr_en ? (ex_funct3 inside {SB, SH, SW}) : (ex_funct3 inside {LB, LH, LW, LBU, LHU});
  assign mis = (ex_funct3[1:0] == 2'b01 && ex_addr[0]) || (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00);
  assign bad = (ex_rd_en && ex_wr_en) || !f3_ok || mis;
  assign st_be = ex_funct3 == SB ? 4'b0001 << ex_addr[1:0] :
                 ex_funct3 == SH ? (ex_addr[1] ? BE_HALF_HI : BE_HALF_LO) : BE_WORD;
  assign st_wdata = ex_funct3 == SB ? {4{ex_wdata[7:0]}} :
                    ex_funct3 == SH ? {2{ex_wdata[15:0]}} : ex_wdata;
  assign mem_req = state == ST_REQ;
  assign stall = (state == ST_IDLE && new_acc) || state == ST_REQ || state == ST_WAIT;
  assign ld_valid = state == ST_DONE && !mem_we;
  assign err = state == ST_ERR;
  lsu_load_align u_align (.rdata(mem_rdata), .addr(ld_lo), .funct3(ld_f3), .result(ld_res));
`ifdef LSU_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  assign tmo = (state == ST_REQ || state == ST_WAIT) && tmo_cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    tmo_cnt <= (reset || !(state == ST_REQ || state == ST_WAIT)) ? '0 : tmo_cnt + 16'd1;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign tmo = 1'b0;
`endif
  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE: nxt = new_acc ? (bad ? ST_ERR : ST_REQ) : ST_IDLE;
      ST_REQ:  nxt = mem_gnt ? (mem_we ? ST_DONE : ST_WAIT) : ST_REQ;
      ST_WAIT: nxt = mem_rvalid ? ST_DONE : ST_WAIT;
      default: nxt = ST_IDLE;
    endcase
    if (tmo) nxt = ST_ERR;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      ld_f3 <= '0;
      ld_lo <= '0;
      ld_data <= '0;
    end else begin
      state <= nxt;
      if (state == ST_IDLE && new_acc && !bad) begin
        mem_we <= ex_wr_en;
        mem_addr <= {ex_addr[31:2], 2'b00};
        mem_be <= ex_wr_en ? st_be : BE_WORD;
        mem_wdata <= st_wdata;
        ld_f3 <= ex_funct3;
        ld_lo <= ex_addr[1:0];
      end
      if (state == ST_WAIT && mem_rvalid) ld_data <= ld_res;
      if (nxt == ST_ERR) ld_data <= '0;
    end
  end
endmodule
